// File: rtl/frame_scheduler.sv
// Frame scheduler: launches one draw per scene, waits for draw and raster drain,
// then swaps framebuffers on vsync. A stuck frame is aborted by a cycle timeout.
module frame_scheduler #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              create_done,
  input  logic              spi_busy,
  output logic              draw_start,
  input  logic              draw_done,
  input  logic              raster_idle,
  input  logic              vsync,
  output logic              buf_sel,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout_err,
  output logic              busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACK,
    DRAW,
    DRAIN,
    WAIT_VSYNC,
    SWAP
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;

  // ACK only looks for draw_done low, so a done level left over from the
  // previous frame can never be mistaken for completion of this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      draw_start  <= 1'b0;
      buf_sel     <= 1'b0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      tcnt        <= '0;
    end else begin
      draw_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && create_done && !spi_busy) begin
            state      <= START;
            draw_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        START: begin
          tcnt  <= '0;
          state <= ACK;
        end
        ACK, DRAW, DRAIN: begin
          // Timeout wins over any transition that would happen on the same edge.
          if (tcnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (state == ACK && !draw_done) begin
              state <= DRAW;
            end else if (state == DRAW && draw_done) begin
              state <= DRAIN;
            end else if (state == DRAIN && raster_idle) begin
              state <= WAIT_VSYNC;
            end
          end
        end
        WAIT_VSYNC: begin
          if (vsync) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          buf_sel   <= ~buf_sel;
          frame_cnt <= frame_cnt + FCNT_W'(1);
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a short-timeout instance covers the abort
// path, the main instance covers frames, gating, counter wrap and reset.
module tb_frame_scheduler;

  logic clk;
  logic rst;
  logic enable;
  logic create_done;
  logic spi_busy;
  logic draw_done;
  logic raster_idle;
  logic vsync;

  logic        draw_start0;
  logic        buf_sel0;
  logic [1:0]  frame_cnt0;
  logic        timeout_err0;
  logic        busy0;

  logic        draw_start1;
  logic        buf_sel1;
  logic [15:0] frame_cnt1;
  logic        timeout_err1;
  logic        busy1;

  int vectors;
  int miscompares;
  int ds_count;
  int ds0;
  logic [2:0] exp_q[$];

  frame_scheduler #(.TIMEOUT_CYCLES(1000), .FCNT_W(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .create_done(create_done),
    .spi_busy(spi_busy), .draw_start(draw_start0), .draw_done(draw_done),
    .raster_idle(raster_idle), .vsync(vsync), .buf_sel(buf_sel0),
    .frame_cnt(frame_cnt0), .timeout_err(timeout_err0), .busy(busy0)
  );

  frame_scheduler #(.TIMEOUT_CYCLES(64), .FCNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .enable(enable), .create_done(create_done),
    .spi_busy(spi_busy), .draw_start(draw_start1), .draw_done(draw_done),
    .raster_idle(raster_idle), .vsync(vsync), .buf_sel(buf_sel1),
    .frame_cnt(frame_cnt1), .timeout_err(timeout_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts draw_start pulses of the main instance, one per high cycle.
  always @(posedge clk) begin
    if (draw_start0) ds_count = ds_count + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    assert (observed === expected) else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cd, input logic sb,
                               input logic dd, input logic ri);
    enable      = en;
    create_done = cd;
    spi_busy    = sb;
    draw_done   = dd;
    raster_idle = ri;
  endtask

  task automatic waitDrawStart(input string tag);
    int n;
    n = 0;
    while (!draw_start0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_start_seen"}, 32'(draw_start0), 32'd1);
  endtask

  task automatic pulseVsync();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
  endtask

  // Pops the expected {buf_sel, frame_cnt} once the DUT shows a swap.
  task automatic waitSwap(input string tag);
    logic [2:0] prev;
    logic [2:0] exp_val;
    int cyc;
    prev = {buf_sel0, frame_cnt0};
    cyc = 0;
    while ({buf_sel0, frame_cnt0} == prev && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_swap_seen"}, 32'({buf_sel0, frame_cnt0} != prev), 32'd1);
    checkOutput({tag, "_swap_latency"}, 32'(cyc), 32'd1);
    exp_val = exp_q.pop_front();
    checkOutput({tag, "_swap_value"}, 32'({buf_sel0, frame_cnt0}), 32'(exp_val));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    ds_count = 0;
    rst = 1'b1;
    vsync = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("rst_draw_start", 32'(draw_start0), 32'd0);
    checkOutput("rst_buf_sel", 32'(buf_sel0), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt0), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err0), 32'd0);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle_no_start", 32'(ds_count), 32'd0);

    // Nominal frame
    ds0 = ds_count;
    exp_q.push_back({1'b1, 2'd1});
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    waitDrawStart("nom");
    spi_busy = 1'b1;
    checkOutput("nom_busy", 32'(busy0), 32'd1);
    tick(1);
    checkOutput("nom_pulse_width", 32'(draw_start0), 32'd0);
    tick(1);
    draw_done = 1'b0;
    tick(100);
    draw_done = 1'b1;
    tick(50);
    pulseVsync();
    checkOutput("nom_buf_hold", 32'(buf_sel0), 32'd0);
    waitSwap("nom");
    tick(3);
    checkOutput("nom_one_start", 32'(ds_count - ds0), 32'd1);
    checkOutput("nom_idle", 32'(busy0), 32'd0);

    // Stale done level held through ACK, with a vsync that must be ignored
    exp_q.push_back({1'b0, 2'd2});
    spi_busy = 1'b0;
    waitDrawStart("stale");
    spi_busy = 1'b1;
    tick(3);
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
    draw_done = 1'b0;
    checkOutput("stale_buf_hold", 32'(buf_sel0), 32'd1);
    checkOutput("stale_cnt_hold", 32'(frame_cnt0), 32'd1);
    checkOutput("stale_busy", 32'(busy0), 32'd1);
    tick(10);
    draw_done = 1'b1;
    tick(10);
    checkOutput("stale_wait_vsync", 32'(buf_sel0), 32'd1);
    pulseVsync();
    waitSwap("stale");

    // Vsync on the edge entering WAIT_VSYNC
    exp_q.push_back({1'b1, 2'd3});
    spi_busy = 1'b0;
    waitDrawStart("vb");
    spi_busy = 1'b1;
    tick(2);
    draw_done = 1'b0;
    tick(10);
    draw_done = 1'b1;
    tick(1);
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(19);
    checkOutput("vb_no_swap_buf", 32'(buf_sel0), 32'd0);
    checkOutput("vb_no_swap_cnt", 32'(frame_cnt0), 32'd2);
    pulseVsync();
    waitSwap("vb");

    // Gating by spi_busy, then enable dropped mid-DRAW (counter wraps to 0)
    ds0 = ds_count;
    tick(5);
    checkOutput("gate_spi_busy", 32'(ds_count - ds0), 32'd0);
    checkOutput("gate_spi_idle", 32'(busy0), 32'd0);
    exp_q.push_back({1'b0, 2'd0});
    spi_busy = 1'b0;
    waitDrawStart("gate");
    tick(2);
    draw_done = 1'b0;
    tick(3);
    enable = 1'b0;
    tick(10);
    draw_done = 1'b1;
    tick(5);
    pulseVsync();
    waitSwap("gate");
    ds0 = ds_count;
    tick(10);
    checkOutput("gate_enable_low", 32'(ds_count - ds0), 32'd0);
    checkOutput("gate_enable_idle", 32'(busy0), 32'd0);

    exp_q.push_back({1'b1, 2'd1});
    enable = 1'b1;
    waitDrawStart("resume");
    tick(2);
    draw_done = 1'b0;
    tick(10);
    draw_done = 1'b1;
    tick(5);
    pulseVsync();
    waitSwap("resume");
    checkOutput("next_start_gap", 32'(draw_start0), 32'd0);
    tick(1);
    checkOutput("next_start", 32'(draw_start0), 32'd1);

    // Reset asserted in DRAW takes effect without a clock edge
    tick(2);
    draw_done = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_buf_sel", 32'(buf_sel0), 32'd0);
    checkOutput("mid_rst_frame_cnt", 32'(frame_cnt0), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy0), 32'd0);
    checkOutput("mid_rst_draw_start", 32'(draw_start0), 32'd0);
    checkOutput("mid_rst_timeout_err", 32'(timeout_err0), 32'd0);
    tick(2);
    draw_done = 1'b1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_no_start", 32'(draw_start0), 32'd0);
    waitDrawStart("post_rst");
    spi_busy = 1'b1;

    // Timeout on the short-timeout instance: draw_done never rises
    rst = 1'b1;
    tick(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    waitDrawStart("to");
    checkOutput("to_start", 32'(draw_start1), 32'd1);
    spi_busy = 1'b1;
    tick(2);
    draw_done = 1'b0;
    tick(62);
    checkOutput("to_before_err", 32'(timeout_err1), 32'd0);
    checkOutput("to_before_busy", 32'(busy1), 32'd1);
    tick(1);
    checkOutput("to_err", 32'(timeout_err1), 32'd1);
    checkOutput("to_idle", 32'(busy1), 32'd0);
    checkOutput("to_frame_cnt", 32'(frame_cnt1), 32'd0);
    checkOutput("to_buf_sel", 32'(buf_sel1), 32'd0);
    tick(10);
    checkOutput("to_err_sticky", 32'(timeout_err1), 32'd1);
    checkOutput("to_main_no_err", 32'(timeout_err0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
